// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: CPU-side state encoding and
// default bus widths.
package vram_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // CPU access state machine encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        ACK     = 2'd3
    } cpuStateT;

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write FIFO. Depth is a power of two so the read/write pointers
// wrap naturally. The caller never pushes when full or pops when empty.
module vram_wbuf #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             pushData,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while not counted as valid
    always_ff @(posedge clk) begin
        if (push) store[wrPtr] <= pushData;
    end

    assign head  = store[rdPtr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter. GPU reads always win and see a fixed 1-cycle
// latency; CPU writes are posted into a small buffer and drained into
// GPU-idle cycles; CPU reads wait until the buffer is drained so they
// observe every earlier write.
//
// CPU handshake: the master raises cpuReq with stable cpuWe/cpuAddr/cpuWData
// and holds it until it sees cpuAck (a one-cycle pulse); it drops cpuReq on
// the edge after the ack. The request is not sampled during the ack cycle.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gpuRe,
    input  logic [ADDR_W-1:0] gpuAddr,
    output logic [DATA_W-1:0] gpuRData,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic [DATA_W-1:0] cpuRData,
    output logic              cpuAck,
    output logic              wbufEmpty,
    output logic              memRe,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    output cpuStateT          cpuState
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CW    = $clog2(WBUF_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WBUF_DEPTH);

    cpuStateT          state;
    cpuStateT          stateNext;
    logic [ADDR_W-1:0] rdAddr;
    logic [ENT_W-1:0]  wbHead;
    logic [CW-1:0]     wbCount;
    logic              wbEmpty;
    logic              wbFull;
    logic              pushReq;
    logic              drain;
    logic              rdIssue;

    // Full is judged on the count before any same-cycle drain, so a write
    // arriving on a full buffer retries even if an entry leaves this cycle.
    assign pushReq = (state == IDLE) && cpuReq && cpuWe && !wbFull;
    assign drain   = !gpuRe && !wbEmpty;
    assign rdIssue = (state == RD_WAIT) && !gpuRe && wbEmpty;

    vram_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .W     (ENT_W)
    ) u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .push     (pushReq),
        .pushData ({cpuAddr, cpuWData}),
        .pop      (drain),
        .head     (wbHead),
        .count    (wbCount),
        .empty    (wbEmpty),
        .full     (wbFull)
    );

    // Occupancy count and full flag from the buffer must always agree
    always_ff @(posedge clk) begin
        if (!rst) assert (wbFull == (wbCount == CNT_FULL));
    end

    // CPU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // CPU next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (cpuReq && cpuWe && !wbFull) stateNext = ACK;
                else if (cpuReq && !cpuWe)      stateNext = RD_WAIT;
            end
            RD_WAIT: if (rdIssue) stateNext = RD_DATA;
            RD_DATA: stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Read address latch and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdAddr   <= '0;
            cpuRData <= '0;
        end else begin
            if (state == IDLE && cpuReq && !cpuWe) rdAddr   <= cpuAddr;
            if (state == RD_DATA)                  cpuRData <= memRData;
        end
    end

    // Memory port mux: GPU read, then write drain, then CPU read issue
    always_comb begin
        memRe    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        if (gpuRe) begin
            memRe   = 1'b1;
            memAddr = gpuAddr;
        end else if (!wbEmpty) begin
            memWe    = 1'b1;
            memAddr  = wbHead[ENT_W-1 -: ADDR_W];
            memWData = wbHead[DATA_W-1:0];
        end else if (rdIssue) begin
            memRe   = 1'b1;
            memAddr = rdAddr;
        end
    end

    assign gpuRData  = memRData;
    assign cpuAck    = (state == ACK);
    assign wbufEmpty = wbEmpty;
    assign cpuState  = state;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port VRAM.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clk;
    logic        rst;
    logic        gpuRe;
    logic [15:0] gpuAddr;
    logic [15:0] gpuRData;
    logic        cpuReq;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWData;
    logic [15:0] cpuRData;
    logic        cpuAck;
    logic        wbufEmpty;
    logic        memRe;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic [15:0] memRData;
    cpuStateT    cpuState;

    int nCompared = 0;
    int nMism     = 0;

    logic [15:0] mem [4096];
    logic [31:0] exp_q[$];
    logic [31:0] act_q[$];

    vram_arbiter #(.ADDR_W(16), .DATA_W(16), .WBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .gpuRe(gpuRe), .gpuAddr(gpuAddr), .gpuRData(gpuRData),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
        .cpuRData(cpuRData), .cpuAck(cpuAck), .wbufEmpty(wbufEmpty),
        .memRe(memRe), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .cpuState(cpuState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: synchronous write, registered read data, write log
    always @(posedge clk) begin
        if (memWe) begin
            mem[memAddr[11:0]] <= memWData;
            act_q.push_back({memAddr, memWData});
        end
        if (memRe) memRData <= mem[memAddr[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic toSample();
        @(negedge clk);
    endtask

    task automatic cpuDrive(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        cpuReq   = req;
        cpuWe    = we;
        cpuAddr  = a;
        cpuWData = d;
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, "_memWe"}, 32'(memWe), 32'd0);
        check({tag, "_ack"}, 32'(cpuAck), 32'd0);
        check({tag, "_empty"}, 32'(wbufEmpty), 32'd1);
        check({tag, "_state"}, 32'(cpuState), 32'(IDLE));
    endtask

    logic pat [9];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hC3C3;
        mem[16'h0010] = 16'hBEEF;
        memRData = '0;
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---- reset state ----
        rst = 1'b1;
        gpuRe = 1'b0;
        gpuAddr = '0;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        toSample();
        check("rst_memRe", 32'(memRe), 32'd0);
        check("rst_memAddr", 32'(memAddr), 32'd0);
        check("rst_memWData", 32'(memWData), 32'd0);
        check("rst_cpuRData", 32'(cpuRData), 32'd0);
        check("rst_gpuRData", 32'(gpuRData), 32'd0);
        checkQuiet("rst");
        nextCycle();
        rst = 1'b0;
        toSample();
        checkQuiet("idle");
        check("idle_memRe", 32'(memRe), 32'd0);
        nextCycle();

        // ---- GPU read pulse ----
        gpuRe = 1'b1;
        gpuAddr = 16'h0010;
        toSample();
        check("gpu_memRe", 32'(memRe), 32'd1);
        check("gpu_memAddr", 32'(memAddr), 32'h0010);
        nextCycle();
        gpuRe = 1'b0;
        gpuAddr = 16'h0;
        toSample();
        check("gpu_rdata", 32'(gpuRData), 32'hBEEF);
        check("gpu_off_memRe", 32'(memRe), 32'd0);
        nextCycle();

        // ---- single CPU write ----
        cpuDrive(1'b1, 1'b1, 16'h0200, 16'h1234);
        exp_q.push_back({16'h0200, 16'h1234});
        toSample();
        check("w1_ack_t", 32'(cpuAck), 32'd0);
        nextCycle();
        toSample();
        check("w1_ack", 32'(cpuAck), 32'd1);
        check("w1_memWe", 32'(memWe), 32'd1);
        check("w1_memAddr", 32'(memAddr), 32'h0200);
        check("w1_memWData", 32'(memWData), 32'h1234);
        nextCycle();
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        toSample();
        checkQuiet("w1_done");
        nextCycle();

        // ---- three writes under continuous GPU traffic ----
        gpuRe = 1'b1;
        gpuAddr = 16'h0040;
        exp_q.push_back({16'h0A00, 16'h1111});
        exp_q.push_back({16'h0A01, 16'h2222});
        exp_q.push_back({16'h0A02, 16'h3333});
        cpuDrive(1'b1, 1'b1, 16'h0A00, 16'h1111);
        toSample(); check("b_c0_ack", 32'(cpuAck), 32'd0); nextCycle();
        toSample(); check("b_c1_ack", 32'(cpuAck), 32'd1); nextCycle();
        cpuDrive(1'b1, 1'b1, 16'h0A01, 16'h2222);
        toSample(); check("b_c2_ack", 32'(cpuAck), 32'd0); nextCycle();
        toSample(); check("b_c3_ack", 32'(cpuAck), 32'd1); nextCycle();
        cpuDrive(1'b1, 1'b1, 16'h0A02, 16'h3333);
        toSample();
        check("b_c4_ack", 32'(cpuAck), 32'd0);
        check("b_c4_state", 32'(cpuState), 32'(IDLE));
        check("b_c4_memWe", 32'(memWe), 32'd0);
        nextCycle();
        toSample();
        check("b_c5_ack", 32'(cpuAck), 32'd0);
        check("b_c5_memRe", 32'(memRe), 32'd1);
        nextCycle();
        gpuRe = 1'b0;
        toSample();
        check("b_c6_ack", 32'(cpuAck), 32'd0);
        check("b_c6_state", 32'(cpuState), 32'(IDLE));
        check("b_c6_memAddr", 32'(memAddr), 32'h0A00);
        nextCycle();
        toSample();
        check("b_c7_ack", 32'(cpuAck), 32'd0);
        check("b_c7_memAddr", 32'(memAddr), 32'h0A01);
        nextCycle();
        toSample();
        check("b_c8_ack", 32'(cpuAck), 32'd1);
        check("b_c8_memAddr", 32'(memAddr), 32'h0A02);
        nextCycle();
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        toSample();
        checkQuiet("b_done");
        nextCycle();

        // ---- write then read-after-write under 5-of-8 slot pattern ----
        exp_q.push_back({16'h0300, 16'h5A5A});
        for (int k = 0; k < 9; k++) begin
            gpuRe = pat[k];
            gpuAddr = 16'h0100 + 16'(k);
            if (k < 2)      cpuDrive(1'b1, 1'b1, 16'h0300, 16'h5A5A);
            else if (k < 8) cpuDrive(1'b1, 1'b0, 16'h0300, 16'h0);
            else            cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
            toSample();
            if (pat[k]) begin
                check($sformatf("s%0d_gpu_memRe", k), 32'(memRe), 32'd1);
                check($sformatf("s%0d_gpu_addr", k), 32'(memAddr), 32'(16'h0100 + 16'(k)));
                check($sformatf("s%0d_gpu_noWe", k), 32'(memWe), 32'd0);
            end
            if (k > 0 && pat[k-1])
                check($sformatf("s%0d_gpu_rdata", k), 32'(gpuRData),
                      32'((16'h0100 + 16'(k - 1)) ^ 16'hC3C3));
            case (k)
                1: check("s1_ack", 32'(cpuAck), 32'd1);
                2: begin
                    check("s2_memWe", 32'(memWe), 32'd1);
                    check("s2_memAddr", 32'(memAddr), 32'h0300);
                    check("s2_memWData", 32'(memWData), 32'h5A5A);
                end
                3, 4: check($sformatf("s%0d_state", k), 32'(cpuState), 32'(RD_WAIT));
                5: begin
                    check("s5_memRe", 32'(memRe), 32'd1);
                    check("s5_memAddr", 32'(memAddr), 32'h0300);
                    check("s5_memWe", 32'(memWe), 32'd0);
                end
                6: check("s6_state", 32'(cpuState), 32'(RD_DATA));
                7: begin
                    check("s7_ack", 32'(cpuAck), 32'd1);
                    check("s7_cpuRData", 32'(cpuRData), 32'h5A5A);
                end
                default: check($sformatf("s%0d_ack", k), 32'(cpuAck), 32'd0);
            endcase
            nextCycle();
        end
        gpuRe = 1'b0;

        // ---- reset during RD_WAIT with a buffered write pending ----
        gpuRe = 1'b1;
        gpuAddr = 16'h0050;
        cpuDrive(1'b1, 1'b1, 16'h0400, 16'h7777);
        toSample(); nextCycle();
        toSample(); check("r_c1_ack", 32'(cpuAck), 32'd1); nextCycle();
        cpuDrive(1'b1, 1'b0, 16'h0400, 16'h0);
        toSample(); nextCycle();
        toSample();
        check("r_c3_state", 32'(cpuState), 32'(RD_WAIT));
        check("r_c3_empty", 32'(wbufEmpty), 32'd0);
        nextCycle();
        rst = 1'b1;
        gpuRe = 1'b0;
        cpuDrive(1'b0, 1'b0, 16'h0, 16'h0);
        toSample();
        checkQuiet("r_in");
        nextCycle();
        toSample();
        checkQuiet("r_hold");
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            toSample();
            checkQuiet($sformatf("r_post%0d", c));
            check($sformatf("r_post%0d_memRe", c), 32'(memRe), 32'd0);
            nextCycle();
        end

        // ---- write order scoreboard ----
        check("wr_count", 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("wr_%0d", i), act_q[i], exp_q[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMism);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous video RAM between the GPU fetch path and the CPU bus. The GPU read port has absolute priority and a fixed 1-cycle latency, so the scanout slot schedule is never disturbed. CPU accesses use a req/ack handshake:
- Writes are posted into a small write buffer and drained into idle memory cycles.
- Reads wait for the buffer to drain and for a free cycle.

The block sits between the GPU control unit/video fetch registers, the CPU memory bus, and the VRAM macro.

## Interface
Parameters:
- ADDR_W, 16, VRAM address width
- DATA_W, 16, VRAM data width
- WBUF_DEPTH, 2, write buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- gpuRe  in  1  GPU read request this cycle, always served
- gpuAddr  in  ADDR_W  GPU read address
- gpuRData  out  DATA_W  GPU read data, valid the cycle after gpuRe
- cpuReq  in  1  CPU request, held with stable cpuWe/cpuAddr/cpuWData until cpuAck
- cpuWe  in  1  1 = write, 0 = read
- cpuAddr  in  ADDR_W  CPU address
- cpuWData  in  DATA_W  CPU write data
- cpuRData  out  DATA_W  CPU read data, registered, valid while cpuAck=1
- cpuAck  out  1  one-cycle completion pulse
- wbufEmpty  out  1  write buffer empty
- memRe  out  1  VRAM read enable
- memWe  out  1  VRAM write enable
- memAddr  out  ADDR_W  VRAM address
- memWData  out  DATA_W  VRAM write data
- memRData  in  DATA_W  VRAM read data, 1 cycle after memRe

## Operation
Memory port priority, evaluated every cycle:
1. GPU read: gpuRe=1 → memRe=1, memAddr=gpuAddr.
2. Write drain: buffer non-empty → memWe=1 with the head entry, which is popped.
3. CPU read issue: in RD_WAIT with the buffer empty.

When no access is made, memAddr=0 and memWData=0.

gpuRData is memRData passed through combinationally. It is meaningful only in the cycle after gpuRe.

CPU state machine (2-bit):
- IDLE
  - cpuReq & cpuWe & count<WBUF_DEPTH → push {cpuAddr, cpuWData}, go to ACK.
  - cpuReq & cpuWe & full → stay in IDLE; the request retries. The full check uses the count before any same-cycle pop.
  - cpuReq & !cpuWe → latch cpuAddr, go to RD_WAIT.
- RD_WAIT: when !gpuRe and the buffer is empty → memRe=1 with the latched address, go to RD_DATA. Otherwise wait.
- RD_DATA: capture memRData into cpuRData, go to ACK.
- ACK: cpuAck=1, go to IDLE. cpuReq is not sampled in ACK; the master drops cpuReq on the edge after the ack.

Buffer rules:
- Push and pop in the same cycle are allowed; count is unchanged.
- FIFO order is preserved.
- Reads drain all posted writes first, so read-after-write returns the new data.

## Timing
- Reset value of all outputs is 0, except wbufEmpty=1. At reset the state is IDLE, the buffer is empty and cpuRData=0.
- GPU: memRe is asserted in the same cycle as gpuRe; gpuRData follows 1 cycle later. GPU accesses are never stalled.
- CPU write, request at cycle t in IDLE with the buffer not full:
  - ack at t+1;
  - VRAM write at the first cycle ≥ t+1 with no gpuRe (and no older entry ahead of it).
- CPU read, request at cycle t with the buffer empty and gpuRe=0 at t+1:
  - memRe at t+1;
  - capture at the end of t+2;
  - cpuAck and cpuRData at t+3.
- Each cycle of gpuRe or pending drain adds one cycle of latency.
- With the 8-cycle scanout pattern (5 fetch slots), a read waits at most 5 + WBUF_DEPTH cycles before issue.
- Reset asserted mid-operation: buffered writes are discarded, any pending read is abandoned, and no ack is issued.

## Structure
- Shared package `vram_pkg`:
  - CPU state encoding: IDLE=0, RD_WAIT=1, RD_DATA=2, ACK=3;
  - default ADDR_W/DATA_W constants.
- Sub-module `vram_wbuf`: parameterised FIFO with push/pop/head/count/empty/full and an async reset. It uses a pointer wrap on the power-of-two depth.

## Test plan
- Reset then idle:
  - all outputs 0, wbufEmpty=1;
  - gpuRe pulse at addr 0x0010 with memRData=0xBEEF → memRe/memAddr=0x0010 in the same cycle, gpuRData=0xBEEF the next cycle.
- CPU write 0x1234 → 0x0200 with gpuRe=0:
  - cpuAck 1 cycle later;
  - memWe with memAddr=0x0200, memWData=0x1234 on the following cycle;
  - wbufEmpty returns to 1.
- Three back-to-back writes while gpuRe is held high:
  - first two acked;
  - third stalls in IDLE until gpuRe drops and a drain frees an entry;
  - VRAM receives the writes in issue order.
- Write 0x5A5A → 0x0300, then read 0x0300 while gpuRe follows the 5-of-8 slot pattern:
  - the read issues only after the drain and in a gpuRe=0 cycle;
  - cpuRData=0x5A5A;
  - the GPU never misses a cycle.
- Assert rst during RD_WAIT with one buffered write pending:
  - no memWe, no cpuAck;
  - after release, state is IDLE and wbufEmpty=1.
